// File: rtl/dram_burst_rw_ctrl.sv
// Burst write/read/refresh sequencer driving a DRAM macro's row, data and phase-enable pins.
// Optional idle-time auto refresh is compiled in with `define DRAM_AUTO_REFRESH_EN.
module dram_burst_rw_ctrl #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned LEN_W        = 3,
  parameter int unsigned T_WL         = 2,
  parameter int unsigned T_SA         = 2,
  parameter int unsigned REF_INTERVAL = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     IO_EN,
  input  logic [1:0]               IO_MODEL,
  input  logic [ADDR_W-1:0]        IO_ADDR,
  input  logic [LEN_W-1:0]         IO_LEN,
  input  logic [DATA_W-1:0]        DRAM16_data,
  input  logic [DATA_W-1:0]        SA_OUT,
  output logic                     WR_READY,
  output logic [DATA_W-1:0]        RD_DATA,
  output logic                     RD_VALID,
  output logic                     BUSY,
  output logic                     WT_DONE,
  output logic                     RD_DONE,
  output logic                     RF_DONE,
  output logic                     ERR,
  output logic [DATA_W-1:0]        D_IN,
  output logic                     DATA_VALID_IN,
  output logic [(1<<ADDR_W)-1:0]   R_AD,
  output logic                     WRI_EN,
  output logic                     RD_EN,
  output logic                     VSAEN,
  output logic                     REF_WWL
);

  localparam int unsigned ROWS  = 1 << ADDR_W;
  localparam int unsigned REM_W = (LEN_W > ADDR_W) ? LEN_W : ADDR_W;
  localparam int unsigned T_MAX = (T_WL > T_SA) ? T_WL : T_SA;
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StRdWl = 3'd3;
  localparam logic [2:0] StRdSa = 3'd4;
  localparam logic [2:0] StRef = 3'd5;
  localparam logic [2:0] StNext = 3'd6;
  localparam logic [2:0] StDone = 3'd7;

  localparam logic [1:0] ModeWr = 2'b01;
  localparam logic [1:0] ModeRd = 2'b10;
  localparam logic [1:0] ModeRf = 2'b11;

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] d_in_q, d_in_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic              row_last;

`ifdef DRAM_AUTO_REFRESH_EN
  localparam int unsigned IC_W = $clog2(REF_INTERVAL + 1);
  logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            pending_q, pending_d;
`else
  logic unused_ref_interval;
  assign unused_ref_interval = ^REF_INTERVAL;
`endif

  assign row_last = (rem_q == '0);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    row_d     = row_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    d_in_d    = d_in_q;
    rd_data_d = rd_data_q;
    err_d     = IO_EN && (state_q != StIdle);
`ifdef DRAM_AUTO_REFRESH_EN
    idle_cnt_d = idle_cnt_q;
    pending_d  = pending_q;
    if (state_q == StIdle && !pending_q) begin
      if (idle_cnt_q == IC_W'(REF_INTERVAL - 1)) pending_d = 1'b1;
      else idle_cnt_d = idle_cnt_q + IC_W'(1);
    end
`endif
    case (state_q)
      StIdle: begin
`ifdef DRAM_AUTO_REFRESH_EN
        // A pending auto refresh wins over any host command presented alongside it.
        if (pending_q) begin
          err_d      = IO_EN;
          mode_d     = ModeRf;
          row_d      = '0;
          rem_d      = REM_W'(ROWS - 1);
          state_d    = StLoad;
          idle_cnt_d = '0;
          pending_d  = 1'b0;
        end else
`endif
        if (IO_EN) begin
          if (IO_MODEL == 2'b00) begin
            err_d = 1'b1;
          end else begin
            mode_d  = IO_MODEL;
            row_d   = (IO_MODEL == ModeRf) ? '0 : IO_ADDR;
            rem_d   = (IO_MODEL == ModeRf) ? REM_W'(ROWS - 1) : REM_W'(IO_LEN);
            state_d = StLoad;
`ifdef DRAM_AUTO_REFRESH_EN
            if (IO_MODEL == ModeRf) idle_cnt_d = '0;
`endif
          end
        end
      end
      StLoad: begin
        cnt_d = '0;
        if (mode_q == ModeWr) begin
          d_in_d  = DRAM16_data;
          state_d = StWrite;
        end else if (mode_q == ModeRd) begin
          state_d = StRdWl;
        end else begin
          state_d = StRef;
        end
      end
      StWrite, StRef: begin
        if (cnt_q == CNT_W'(T_WL - 1)) state_d = row_last ? StDone : StNext;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      StRdWl: begin
        if (cnt_q == CNT_W'(T_WL - 1)) begin
          cnt_d   = '0;
          state_d = StRdSa;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRdSa: begin
        if (cnt_q == CNT_W'(T_SA - 1)) begin
          rd_data_d = SA_OUT;
          state_d   = row_last ? StDone : StNext;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StNext: begin
        row_d   = row_q + ADDR_W'(1);
        rem_d   = rem_q - REM_W'(1);
        state_d = StLoad;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 2'b00;
      row_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      d_in_q     <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef DRAM_AUTO_REFRESH_EN
      idle_cnt_q <= '0;
      pending_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      row_q      <= row_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      d_in_q     <= d_in_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
`ifdef DRAM_AUTO_REFRESH_EN
      idle_cnt_q <= idle_cnt_d;
      pending_q  <= pending_d;
`endif
    end
  end

  always_comb begin
    R_AD = '0;
    if (state_q inside {StLoad, StWrite, StRdWl, StRdSa, StRef}) R_AD[row_q] = 1'b1;
  end

  assign BUSY          = (state_q != StIdle);
  assign WR_READY      = (state_q == StLoad) && (mode_q == ModeWr);
  assign WRI_EN        = (state_q == StWrite);
  assign DATA_VALID_IN = (state_q == StWrite);
  assign RD_EN         = (state_q == StRdWl);
  assign VSAEN         = (state_q == StRdSa);
  assign REF_WWL       = (state_q == StRef);
  assign RD_VALID      = (state_q == StNext || state_q == StDone) && (mode_q == ModeRd);
  assign WT_DONE       = (state_q == StDone) && (mode_q == ModeWr);
  assign RD_DONE       = (state_q == StDone) && (mode_q == ModeRd);
  assign RF_DONE       = (state_q == StDone) && (mode_q == ModeRf);
  assign ERR           = err_q;
  assign D_IN          = d_in_q;
  assign RD_DATA       = rd_data_q;

endmodule

// File: tb/tb_dram_burst_rw_ctrl.sv
// Bench for dram_burst_rw_ctrl: per-cycle comparison against a burst timeline built from row
// costs, with randomized data, bursts and rejected-command injection.
module tb_dram_burst_rw_ctrl;
  localparam int DW = 16, AW = 4, LW = 3, TWL = 2, TSA = 2, ROWS = 16;

  logic          clk, rst_n, IO_EN;
  logic [1:0]    IO_MODEL;
  logic [AW-1:0] IO_ADDR;
  logic [LW-1:0] IO_LEN;
  logic [DW-1:0] DRAM16_data, SA_OUT, RD_DATA, D_IN;
  logic          WR_READY, RD_VALID, BUSY, WT_DONE, RD_DONE, RF_DONE, ERR, DATA_VALID_IN;
  logic [ROWS-1:0] R_AD;
  logic          WRI_EN, RD_EN, VSAEN, REF_WWL;

  dram_burst_rw_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .T_WL(TWL), .T_SA(TSA), .REF_INTERVAL(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .IO_EN(IO_EN), .IO_MODEL(IO_MODEL), .IO_ADDR(IO_ADDR),
    .IO_LEN(IO_LEN), .DRAM16_data(DRAM16_data), .SA_OUT(SA_OUT), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY), .WT_DONE(WT_DONE),
    .RD_DONE(RD_DONE), .RF_DONE(RF_DONE), .ERR(ERR), .D_IN(D_IN),
    .DATA_VALID_IN(DATA_VALID_IN), .R_AD(R_AD), .WRI_EN(WRI_EN), .RD_EN(RD_EN),
    .VSAEN(VSAEN), .REF_WWL(REF_WWL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rad;
    logic wri, rd, vsa, rf, dv, wrr, rdv, wtd, rdd, rfd, err;
    logic cap_d, cap_sa;
    logic [4:0] row;
  } cyc_t;

  cyc_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_d, exp_rd;
  bit          fixed_data, sa_is_row;
  logic [27:0] ctl_obs;

  assign ctl_obs = {R_AD, WRI_EN, RD_EN, VSAEN, REF_WWL, DATA_VALID_IN, WR_READY, RD_VALID,
                    WT_DONE, RD_DONE, RF_DONE, BUSY, ERR};

  function automatic logic [27:0] pack_exp(input cyc_t c, input logic busy);
    return {c.rad, c.wri, c.rd, c.vsa, c.rf, c.dv, c.wrr, c.rdv, c.wtd, c.rdd, c.rfd, busy, c.err};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Timeline per row: LOAD, T_WL wordline cycles, T_SA sense cycles (read), then NEXT or DONE.
  task automatic build(input logic [1:0] mode, input int addr, input int nrows);
    cyc_t c;
    bit wr, rdm, rfm;
    wr = (mode == 2'b01); rdm = (mode == 2'b10); rfm = (mode == 2'b11);
    exp_q.delete();
    for (int i = 0; i < nrows; i++) begin
      int row;
      row = (addr + i) % ROWS;
      c = '0; c.rad = 16'(1) << row; c.row = 5'(row); c.wrr = wr; c.cap_d = wr;
      exp_q.push_back(c);
      for (int t = 0; t < TWL; t++) begin
        c = '0; c.rad = 16'(1) << row; c.row = 5'(row);
        c.wri = wr; c.dv = wr; c.rd = rdm; c.rf = rfm;
        exp_q.push_back(c);
      end
      if (rdm) begin
        for (int t = 0; t < TSA; t++) begin
          c = '0; c.rad = 16'(1) << row; c.row = 5'(row); c.vsa = 1'b1;
          c.cap_sa = (t == TSA - 1);
          exp_q.push_back(c);
        end
      end
      c = '0; c.rdv = rdm;
      if (i == nrows - 1) begin
        c.wtd = wr; c.rdd = rdm; c.rfd = rfm;
      end
      exp_q.push_back(c);
    end
  endtask

  task automatic drive_data(input cyc_t c);
    DRAM16_data = fixed_data ? 16'hA5A5 : 16'($urandom);
    SA_OUT      = sa_is_row ? 16'(c.row) : 16'($urandom);
    if (c.cap_d) exp_d = DRAM16_data;
    if (c.cap_sa) exp_rd = SA_OUT;
  endtask

  // Entered and left on a negedge with the DUT idle.
  task automatic run_cmd(input logic [1:0] mode, input int addr, input int len,
                         input int inj_k, input int abort_k, input string tag);
    cyc_t c;
    int nrows;
    nrows = (mode == 2'b11) ? ROWS : len + 1;
    build(mode, (mode == 2'b11) ? 0 : addr, nrows);
    IO_EN = 1'b1; IO_MODEL = mode; IO_ADDR = 4'(addr); IO_LEN = 3'(len);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      IO_EN = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_ctl"}, 64'(ctl_obs), 64'(0));
        check({tag, "_rst_data"}, 64'({D_IN, RD_DATA}), 64'(0));
        exp_d = '0; exp_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      c = exp_q[k];
      c.err = (inj_k >= 0) && (k == inj_k + 1);
      check({tag, "_ctl"}, 64'(ctl_obs), 64'(pack_exp(c, 1'b1)));
      check({tag, "_din"}, 64'(D_IN), 64'(exp_d));
      check({tag, "_rdata"}, 64'(RD_DATA), 64'(exp_rd));
      drive_data(c);
      if (k == inj_k) begin
        IO_EN = 1'b1; IO_MODEL = 2'($urandom); IO_ADDR = 4'($urandom); IO_LEN = 3'($urandom);
      end
    end
    @(negedge clk);
    IO_EN = 1'b0;
    check({tag, "_idle"}, 64'(ctl_obs), 64'(0));
    check({tag, "_idle_din"}, 64'(D_IN), 64'(exp_d));
    check({tag, "_idle_rdata"}, 64'(RD_DATA), 64'(exp_rd));
  endtask

  initial begin
    rst_n = 1'b0; IO_EN = 1'b0; IO_MODEL = 2'b00; IO_ADDR = '0; IO_LEN = '0;
    DRAM16_data = '0; SA_OUT = '0; exp_d = '0; exp_rd = '0;
    fixed_data = 1'b0; sa_is_row = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl", 64'(ctl_obs), 64'(0));
    check("reset_data", 64'({D_IN, RD_DATA}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ctl", 64'(ctl_obs), 64'(0));

    fixed_data = 1'b1;
    run_cmd(2'b01, 3, 0, -1, -1, "wr_a5a5");
    fixed_data = 1'b0;
    check("wr_a5a5_din", 64'(D_IN), 64'(16'hA5A5));

    sa_is_row = 1'b1;
    run_cmd(2'b10, 14, 3, -1, -1, "rd_wrap");
    sa_is_row = 1'b0;
    check("rd_wrap_last", 64'(RD_DATA), 64'(16'd1));

    run_cmd(2'b11, 0, 0, -1, -1, "refresh");

    IO_EN = 1'b1; IO_MODEL = 2'b00;
    @(negedge clk);
    IO_EN = 1'b0;
    check("illegal_err", 64'(ctl_obs), 64'(28'h1));
    @(negedge clk);
    check("illegal_clear", 64'(ctl_obs), 64'(0));

    run_cmd(2'b01, 5, 4, 2, -1, "wr_inj");
    run_cmd(2'b10, 7, 2, 5, -1, "rd_inj");
    run_cmd(2'b10, 9, 5, -1, 7, "rd_abort");
    run_cmd(2'b01, 2, 1, -1, -1, "wr_after_rst");

    for (int n = 0; n < 24; n++) begin
      logic [1:0] m;
      int a, l, inj, nr, sz;
      m  = 2'($urandom_range(1, 3));
      a  = int'($urandom_range(0, ROWS - 1));
      l  = int'($urandom_range(0, 7));
      nr = (m == 2'b11) ? ROWS : l + 1;
      sz = nr * ((m == 2'b10) ? 2 + TWL + TSA : 2 + TWL);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, sz - 2)) : -1;
      run_cmd(m, a, l, inj, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_burst_rw_ctrl.md
# dram_burst_rw_ctrl

Parametrised successor to the single-word DRAM test write/read controller. Accepts a one-cycle command strobe from the host side and sequences multi-row burst writes, burst reads and full-array refresh into the DRAM macro. It drives the macro's row, data and wordline/sense-amp enable pins with programmable pulse widths. Sits between the host/IO logic and the DRAM macro pins.

## Interface
- DATA_W, 16, word width (D_IN, DRAM16_data, SA_OUT, RD_DATA)
- ADDR_W, 4, row address width; array has 2^ADDR_W rows
- LEN_W, 3, burst length field width; burst = IO_LEN+1 rows
- T_WL, 2, wordline pulse width in cycles (WRI_EN / RD_EN / REF_WWL), ≥1
- T_SA, 2, sense-amp enable width in cycles (VSAEN), ≥1
- REF_INTERVAL, 1024, idle cycles between automatic refreshes (used only with the configuration macro)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- IO_EN  in  1  command strobe, sampled only in IDLE
- IO_MODEL  in  2  01 write, 10 read, 11 refresh, 00 illegal
- IO_ADDR  in  ADDR_W  burst start row
- IO_LEN  in  LEN_W  rows minus one
- DRAM16_data  in  DATA_W  host write data, sampled when WR_READY=1
- SA_OUT  in  DATA_W  macro sense-amp output
- WR_READY  out  1  DRAM16_data sampled this cycle
- RD_DATA  out  DATA_W  captured read word
- RD_VALID  out  1  RD_DATA valid, one-cycle pulse per row
- BUSY  out  1  state ≠ IDLE
- WT_DONE / RD_DONE / RF_DONE  out  1 each  one-cycle completion pulses
- ERR  out  1  one-cycle pulse: command rejected
- D_IN  out  DATA_W  data to macro
- DATA_VALID_IN  out  1  D_IN valid
- R_AD  out  2^ADDR_W  one-hot row select
- WRI_EN, RD_EN, VSAEN, REF_WWL  out  1 each  macro phase enables

## Operation
- States: IDLE, LOAD, WRITE, RD_WL, RD_SA, REF, NEXT, DONE.
- IDLE: IO_EN=1 with legal mode latches mode, row=IO_ADDR (refresh: row=0), remaining=IO_LEN (refresh: 2^ADDR_W−1) → LOAD. Mode 00 or IO_EN while BUSY → ignored, ERR pulse.
- LOAD (1 cycle): R_AD=onehot(row). Write: WR_READY=1, D_IN latched from DRAM16_data at cycle end → WRITE. Read → RD_WL. Refresh → REF.
- WRITE: WRI_EN=1, DATA_VALID_IN=1 for T_WL cycles.
- RD_WL: RD_EN=1 for T_WL cycles → RD_SA: VSAEN=1 for T_SA cycles; SA_OUT captured into RD_DATA on last RD_SA edge.
- REF: REF_WWL=1 for T_WL cycles.
- After row phase: remaining=0 → DONE, else NEXT (row=(row+1) mod 2^ADDR_W, remaining−1) → LOAD.
- RD_VALID=1 in the cycle after each RD_SA completes (NEXT or DONE).
- DONE (1 cycle): pulse WT_DONE / RD_DONE / RF_DONE per mode → IDLE.
- R_AD one-hot only in LOAD/WRITE/RD_WL/RD_SA/REF; zero otherwise. D_IN holds last written word.

## Timing
- Reset: all outputs 0, R_AD=0, D_IN=0, RD_DATA=0, state IDLE, counters 0; assertion mid-burst aborts immediately, no done pulse.
- Row cost: write 2+T_WL, read 2+T_WL+T_SA, refresh 2+T_WL cycles (last row: NEXT replaced by DONE).
- 1-row write, T_WL=2: IO_EN sampled edge 0; LOAD cycle 1; WRI_EN cycles 2–3; WT_DONE cycle 4; BUSY low cycle 5.
- Phase enables never overlap; at least one cycle with all enables low between rows (NEXT).
- Row address wraps 2^ADDR_W−1 → 0 within a burst.

## Configuration
- DRAM_AUTO_REFRESH_EN defined: idle counter increments every cycle; at REF_INTERVAL sets refresh_pending. Pending refresh starts from IDLE with priority; a simultaneous IO_EN is rejected with ERR. Counter clears when any refresh starts (host or auto); auto refresh pulses RF_DONE.
- Not defined: no counter or pending logic; refresh only via IO_MODEL=11.

## Test plan
- Write IO_MODEL=01, IO_ADDR=3, IO_LEN=0, data 16'hA5A5 → WR_READY cycle 1, R_AD=16'h0008, D_IN=A5A5, WRI_EN cycles 2–3, WT_DONE cycle 4.
- Read IO_MODEL=10, IO_ADDR=14, IO_LEN=3, SA_OUT=row index → rows 14,15,0,1; four RD_VALID pulses with RD_DATA 14,15,0,1; one RD_DONE.
- Refresh IO_MODEL=11 → REF_WWL pulsed 16 times, rows 0..15 one-hot in order, RF_DONE once, 64 cycles LOAD-to-DONE inclusive.
- IO_EN during burst, and IO_MODEL=00 in IDLE → ERR one cycle each, burst unaffected, no extra done.
- rst_n low mid-read → all outputs 0 asynchronously, no RD_DONE; fresh write afterwards completes normally.
- With DRAM_AUTO_REFRESH_EN, REF_INTERVAL=32: idle 32 cycles → refresh sweep and RF_DONE; IO_EN in refresh start cycle → ERR.
